// File: rtl/scope_pkg.sv
// Shared definitions for the DSO capture/display address generator.
// Holds the capture state encoding, default frame geometry and the
// depth helper used when a capture is armed.
package scope_pkg;

  localparam int unsigned FRAME_LEN  = 200;
  localparam int unsigned MAX_FRAMES = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRETRIG = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Capture depth in samples for a frame_mode value, clamped to the
  // largest supported frame count.
  function automatic int unsigned depth_of(input logic [1:0]  mode,
                                           input int unsigned max_frames,
                                           input int unsigned frame_len);
    int unsigned idx;
    idx = 32'(mode);
    if (idx > max_frames - 1) begin
      idx = max_frames - 1;
    end
    return frame_len * (idx + 1);
  endfunction

endpackage

// File: rtl/scope_rd_window.sv
// Display-side address generator for a completed capture.
// Owns the scroll offset, computes the window base from the trigger
// address and sweeps DISP_LEN consecutive RAM addresses per pass.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   depth               latched capture depth in samples
//   trig_addr_nxt       trigger address as it will be after this edge
//   arm                 restart pulse, clears the offset
//   key_left/key_right  scroll pulses (left wins when both set)
//   done_now/done_nxt   capture FSM is / will be in DONE
//   rd_addr             RAM read address (0 outside DONE)
//   rd_valid            rd_addr meaningful
//   rd_sof              first address of each sweep
module scope_rd_window #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned PRE_TRIG = 50,
  parameter int unsigned DISP_LEN = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W:0]   depth,
  input  logic [ADDR_W-1:0] trig_addr_nxt,
  input  logic              arm,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              done_now,
  input  logic              done_nxt,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              rd_sof
);

  localparam int unsigned DW = ADDR_W + 1;
  localparam int unsigned SW = ADDR_W + 2;
  localparam int unsigned CW = $clog2(DISP_LEN + 1);

  logic [DW-1:0]     offset;
  logic [DW-1:0]     off_max;
  logic [SW-1:0]     sum;
  logic [SW-1:0]     depth_s;
  logic [SW-1:0]     red1;
  logic [SW-1:0]     red2;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rd_inc;
  logic [CW-1:0]     cnt;

  assign off_max = depth - DW'(DISP_LEN);

  // Saturating scroll offset in 0..depth-DISP_LEN.
  always_ff @(posedge clock) begin
    if (reset) begin
      offset <= '0;
    end else if (arm) begin
      offset <= '0;
    end else if (key_left) begin
      if (offset != '0) begin
        offset <= offset - DW'(1);
      end
    end else if (key_right) begin
      if (offset < off_max) begin
        offset <= offset + DW'(1);
      end
    end
  end

  // Window base: sum stays below 3*depth, so two conditional
  // subtractions complete the modulo reduction.
  always_comb begin
    depth_s = SW'(depth);
    sum     = SW'(trig_addr_nxt) + depth_s - SW'(PRE_TRIG) + SW'(offset);
    red1    = (sum  >= depth_s) ? (sum  - depth_s) : sum;
    red2    = (red1 >= depth_s) ? (red1 - depth_s) : red1;
    base    = ADDR_W'(red2);
  end

  assign rd_inc = (DW'(rd_addr) == depth - DW'(1)) ? '0 : rd_addr + ADDR_W'(1);

  // Sweep: reload base on DONE entry and after every DISP_LEN addresses,
  // so offset changes only land at a sweep boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr  <= '0;
      rd_valid <= 1'b0;
      rd_sof   <= 1'b0;
      cnt      <= '0;
    end else if (!done_nxt) begin
      rd_addr  <= '0;
      rd_valid <= 1'b0;
      rd_sof   <= 1'b0;
      cnt      <= '0;
    end else if (!done_now || cnt == CW'(DISP_LEN - 1)) begin
      rd_addr  <= base;
      rd_valid <= 1'b1;
      rd_sof   <= 1'b1;
      cnt      <= '0;
    end else begin
      rd_addr  <= rd_inc;
      rd_valid <= 1'b1;
      rd_sof   <= 1'b0;
      cnt      <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/scope_capture_addr.sv
// Triggered capture and display address generator for the DSO sample RAM.
// A circular write counter fills a depth selected in whole frames, keeps
// PRE_TRIG samples ahead of the trigger, completes the post-trigger fill
// and then hands over to the display window sweep.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   frame_mode          depth select, latched on arm
//   arm                 start/restart capture
//   sample_en           timebase strobe, one write per asserted cycle
//   trigger             trigger event, qualified by sample_en
//   key_left/key_right  display scroll pulses
//   wr_en, wr_addr      RAM write port (wr_en follows sample_en)
//   trig_addr           address of the trigger sample
//   capture_done        capture complete
//   rd_addr, rd_valid,
//   rd_sof              RAM read port and sweep start marker
module scope_capture_addr #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FRAME_LEN  = scope_pkg::FRAME_LEN,
  parameter int unsigned MAX_FRAMES = scope_pkg::MAX_FRAMES,
  parameter int unsigned PRE_TRIG   = 50,
  parameter int unsigned DISP_LEN   = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        frame_mode,
  input  logic              arm,
  input  logic              sample_en,
  input  logic              trigger,
  input  logic              key_left,
  input  logic              key_right,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic              rd_sof
);

  import scope_pkg::*;

  localparam int unsigned DW = ADDR_W + 1;

  state_t            state;
  state_t            state_nxt;
  logic [DW-1:0]     depth_q;
  logic [DW-1:0]     post_len;
  logic [DW-1:0]     post_left;
  logic [ADDR_W-1:0] wr_inc;
  logic [ADDR_W-1:0] trig_nxt;
  logic              capturing;
  logic              trig_hit;

  // Writes still owed after the trigger sample itself.
  assign post_len = depth_q - DW'(PRE_TRIG + 1);
  assign wr_inc   = (DW'(wr_addr) == depth_q - DW'(1)) ? '0 : wr_addr + ADDR_W'(1);
  assign trig_nxt = trig_hit ? wr_addr : trig_addr;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; arm restarts from any state.
  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = PRETRIG;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        // wr_addr starts at 0 on arm, so it doubles as the pre-trigger count.
        PRETRIG: begin
          if (sample_en && wr_addr == ADDR_W'(PRE_TRIG - 1)) begin
            state_nxt = ARMED;
          end
        end
        ARMED: begin
          if (sample_en && trigger) begin
            state_nxt = (post_len == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (sample_en && post_left == DW'(1)) begin
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode for the write side.
  always_comb begin
    capturing = 1'b0;
    case (state)
      PRETRIG, ARMED, POST: capturing = 1'b1;
      default:              capturing = 1'b0;
    endcase
    wr_en    = capturing & sample_en;
    trig_hit = (state == ARMED) & sample_en & trigger & ~arm;
  end

  // Depth latch, circular write counter, trigger capture, post count.
  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q      <= DW'(depth_of(2'd0, MAX_FRAMES, FRAME_LEN));
      wr_addr      <= '0;
      trig_addr    <= '0;
      post_left    <= '0;
      capture_done <= 1'b0;
    end else begin
      capture_done <= (state_nxt == DONE);
      if (arm) begin
        depth_q <= DW'(depth_of(frame_mode, MAX_FRAMES, FRAME_LEN));
        wr_addr <= '0;
      end else if (wr_en) begin
        wr_addr <= wr_inc;
      end
      if (trig_hit) begin
        trig_addr <= wr_addr;
        post_left <= post_len;
      end else if (state == POST && sample_en && !arm) begin
        post_left <= post_left - DW'(1);
      end
    end
  end

  scope_rd_window #(
    .ADDR_W   (ADDR_W),
    .PRE_TRIG (PRE_TRIG),
    .DISP_LEN (DISP_LEN)
  ) u_rd_window (
    .clock         (clock),
    .reset         (reset),
    .depth         (depth_q),
    .trig_addr_nxt (trig_nxt),
    .arm           (arm),
    .key_left      (key_left),
    .key_right     (key_right),
    .done_now      (state == DONE),
    .done_nxt      (state_nxt == DONE),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .rd_sof        (rd_sof)
  );

endmodule

// File: tb/tb_scope_capture_addr.sv
// Scoreboard bench for scope_capture_addr: the stimulus process runs a
// behavioural model of the capture/display rules and queues expected
// outputs; a negedge monitor pops and compares against the DUT.
module tb_scope_capture_addr;

  localparam int unsigned AW   = 10;
  localparam int          PRE  = 50;
  localparam int          DISP = 200;

  logic          clock = 1'b0;
  logic          reset, arm, sample_en, trigger, key_left, key_right;
  logic [1:0]    frame_mode;
  logic          wr_en, capture_done, rd_valid, rd_sof;
  logic [AW-1:0] wr_addr, trig_addr, rd_addr;

  scope_capture_addr dut (
    .clock        (clock),
    .reset        (reset),
    .frame_mode   (frame_mode),
    .arm          (arm),
    .sample_en    (sample_en),
    .trigger      (trigger),
    .key_left     (key_left),
    .key_right    (key_right),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .trig_addr    (trig_addr),
    .capture_done (capture_done),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_sof       (rd_sof)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          wr_en;
    logic [AW-1:0] ptr;
    logic [AW-1:0] trig;
    logic          done;
  } stat_t;

  typedef struct packed {
    logic          sof;
    logic [AW-1:0] addr;
  } rd_t;

  stat_t         sq[$];
  logic [AW-1:0] wq[$];
  rd_t           rq[$];

  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;
  logic [1:0] fm_next = 2'd0;

  // Model state: phase 0 idle, 1 pre-trigger, 2 armed, 3 post, 4 done.
  int m_st, m_depth, m_ptr, m_nw, m_rem, m_trig, m_off, m_k, m_base;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic int calc_base();
    return (m_trig + m_depth - PRE + m_off) % m_depth;
  endfunction

  function automatic void model_reset();
    m_st = 0; m_depth = 200; m_ptr = 0; m_nw = 0; m_rem = 0;
    m_trig = 0; m_off = 0; m_k = 0; m_base = 0;
  endfunction

  // One cycle of the reference: queue this cycle's outputs, then advance.
  function automatic void model_cycle();
    stat_t s;
    rd_t   r;
    bit    wr;
    bit    enter_done;
    int    mode;
    wr = sample_en && (m_st >= 1 && m_st <= 3);
    s.wr_en = wr;
    s.ptr   = AW'(m_ptr);
    s.trig  = AW'(m_trig);
    s.done  = (m_st == 4);
    sq.push_back(s);
    if (wr) wq.push_back(AW'(m_ptr));
    if (m_st == 4) begin
      r.sof  = (m_k == 0);
      r.addr = AW'((m_base + m_k) % m_depth);
      rq.push_back(r);
    end
    if (reset) begin
      model_reset();
      return;
    end
    if (arm) begin
      mode    = int'(frame_mode);
      if (mode > 3) mode = 3;
      m_st    = 1;
      m_depth = 200 * (mode + 1);
      m_ptr   = 0;
      m_nw    = 0;
      m_off   = 0;
      return;
    end
    enter_done = 1'b0;
    case (m_st)
      1: if (wr) begin
        m_nw++;
        if (m_nw == PRE) m_st = 2;
      end
      2: if (wr && trigger) begin
        m_trig = m_ptr;
        m_rem  = m_depth - PRE - 1;
        if (m_rem == 0) enter_done = 1'b1;
        else m_st = 3;
      end
      3: if (wr) begin
        m_rem--;
        if (m_rem == 0) enter_done = 1'b1;
      end
      4: begin
        m_k++;
        if (m_k == DISP) begin
          m_k    = 0;
          m_base = calc_base();
        end
      end
      default: ;
    endcase
    if (wr) m_ptr = (m_ptr + 1) % m_depth;
    if (enter_done) begin
      m_st   = 4;
      m_k    = 0;
      m_base = calc_base();
    end
    if (key_left) begin
      if (m_off > 0) m_off--;
    end else if (key_right) begin
      if (m_off < m_depth - DISP) m_off++;
    end
  endfunction

  task automatic step(input bit a, input bit se, input bit tg, input bit kl, input bit kr, input bit rs);
    @(posedge clock);
    #1;
    frame_mode = fm_next;
    arm = a; sample_en = se; trigger = tg;
    key_left = kl; key_right = kr; reset = rs;
    if (chk_on) model_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  // Step idle until rd_sof is seen, then compare the sweep start address.
  task automatic wait_sof(input int max_cyc, input int exp_addr, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (rd_sof === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s no rd_sof within %0d cycles", name, max_cyc);
    end else begin
      check(name, 32'(rd_addr), exp_addr);
    end
  endtask

  // Monitor: pop expectations whenever the DUT presents outputs.
  stat_t         mon_s;
  logic [AW-1:0] mon_w;
  rd_t           mon_r;
  always @(negedge clock) begin
    if (chk_on && sq.size() > 0) begin
      mon_s = sq.pop_front();
      check("wr_en",        32'(wr_en),        32'(mon_s.wr_en));
      check("wr_addr_reg",  32'(wr_addr),      32'(mon_s.ptr));
      check("trig_addr",    32'(trig_addr),    32'(mon_s.trig));
      check("capture_done", 32'(capture_done), 32'(mon_s.done));
      check("rd_valid",     32'(rd_valid),     32'(mon_s.done));
      if (wr_en === 1'b1) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected addr=%0d", wr_addr);
        end else begin
          mon_w = wq.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(mon_w));
        end
      end
      if (rd_valid === 1'b1) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected addr=%0d", rd_addr);
        end else begin
          mon_r = rq.pop_front();
          check("rd_addr", 32'(rd_addr), 32'(mon_r.addr));
          check("rd_sof",  32'(rd_sof),  32'(mon_r.sof));
        end
      end else begin
        check("rd_idle", 32'({rd_addr, rd_sof}), 0);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; arm = 1'b0; sample_en = 1'b0; trigger = 1'b0;
    key_left = 1'b0; key_right = 1'b0; frame_mode = 2'd0;
    repeat (3) @(posedge clock);
    model_reset();
    chk_on = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    check("rst_wr_addr",   32'(wr_addr), 0);
    check("rst_trig_addr", 32'(trig_addr), 0);
    check("rst_done",      32'(capture_done), 0);
    check("rst_wr_en",     32'(wr_en), 0);

    // Mode 0, trigger on write 120.
    fm_next = 2'd0;
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i <= 120; i++) step(0, 1, i == 120, 0, 0, 0);
    for (int i = 0; i < 149; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("s1_trig_addr", 32'(trig_addr), 120);
    check("s1_done",      32'(capture_done), 1);
    check("s1_first_rd",  32'(rd_addr), 70);
    check("s1_first_sof", 32'(rd_sof), 1);
    check("s1_wr_frozen", 32'(wr_addr), 70);
    idle(199);
    step(0, 0, 0, 0, 0, 0);
    check("s1_resweep", 32'(rd_addr), 70);
    idle(30);

    // Triggers during pre-trigger fill are ignored.
    step(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
    check("s2_not_done", 32'(capture_done), 0);
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 149; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("s2_done", 32'(capture_done), 1);
    check("s2_trig", 32'(trig_addr), 60);
    idle(20);

    // Mode 1 scroll: base 50, offsets 5, 200 (saturated), 199.
    fm_next = 2'd1;
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i <= 100; i++) step(0, 1, i == 100, 0, 0, 0);
    for (int i = 0; i < 349; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("s3_first_rd", 32'(rd_addr), 50);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
    end
    idle(1);
    wait_sof(400, 55, "s3_off5");
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
    end
    idle(1);
    wait_sof(400, 250, "s3_off_sat");
    step(0, 0, 0, 1, 1, 0);
    idle(1);
    wait_sof(400, 249, "s3_both_keys");

    // Key mid-sweep: current sweep intact, next starts one later.
    idle(50);
    step(0, 0, 0, 0, 1, 0);
    wait_sof(400, 250, "s4_mid_sweep");
    idle(10);

    // Strobe every 4th cycle; triggers off-strobe are ignored.
    fm_next = 2'd0;
    step(1, 0, 0, 0, 0, 0);
    for (int w = 0; w < 80; w++) begin
      repeat (3) step(0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
    end
    step(0, 0, 1, 0, 0, 0);
    check("s5_wr_addr", 32'(wr_addr), 80);
    repeat (2) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    for (int w = 0; w < 149; w++) begin
      repeat (3) step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    check("s5_done", 32'(capture_done), 1);
    check("s5_trig", 32'(trig_addr), 80);
    idle(10);

    // Reset in POST.
    fm_next = 2'd2;
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) step(0, 1, i == 70, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1, 0);
    check("s6_rst_wr_en",  32'(wr_en), 0);
    check("s6_rst_wr",     32'(wr_addr), 0);
    check("s6_rst_trig",   32'(trig_addr), 0);
    check("s6_rst_done",   32'(capture_done), 0);
    check("s6_rst_rd",     32'({rd_addr, rd_valid, rd_sof}), 0);

    // Arm while DONE (mode 3).
    fm_next = 2'd3;
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i <= 50; i++) step(0, 1, i == 50, 0, 0, 0);
    for (int i = 0; i < 749; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("s6_done", 32'(capture_done), 1);
    check("s6_rd0",  32'(rd_addr), 0);
    idle(5);
    fm_next = 2'd0;
    step(1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    check("s6_arm_wr",   32'(wr_addr), 0);
    check("s6_arm_done", 32'(capture_done), 0);
    check("s6_arm_wren", 32'(wr_en), 1);

    // Random traffic.
    for (int n = 0; n < 6000; n++) begin
      bit a, rs;
      fm_next = 2'($urandom_range(0, 3));
      a  = (n == 0) || ($urandom_range(0, 1499) == 0);
      rs = ($urandom_range(0, 3999) == 0);
      step(a, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0, rs);
    end

    idle(3);
    @(negedge clock);
    #1;
    chk_on = 1'b0;
    check("sq_drained", sq.size(), 0);
    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scope_capture_addr.md
Name: scope_capture_addr

Overview:
- Triggered capture and display address generator for the DSO sample RAM; successor to the fixed 200/400-point address counter.
- Write side: depth is selectable in whole frames, writes are gated by a timebase strobe, and the write counter wraps as a circular pre-trigger buffer.
- After a trigger it completes the post-trigger fill, freezes the write side and sweeps a scrollable display window.
- Sits between the ADC/timebase logic, trigger comparator, key debouncer and the dual-port sample RAM / display scanner.

Parameters:
- ADDR_W, 10, RAM address width; FRAME_LEN*MAX_FRAMES must not exceed 2^ADDR_W.
- FRAME_LEN, 200, samples per frame (one screen width).
- MAX_FRAMES, 4, maximum selectable depth in frames.
- PRE_TRIG, 50, samples retained before the trigger; must be less than FRAME_LEN.
- DISP_LEN, 200, display window length; must not exceed FRAME_LEN.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_mode  in  2  depth select: depth = FRAME_LEN*(frame_mode+1); values above MAX_FRAMES-1 clamp to MAX_FRAMES-1.
- arm  in  1  single-cycle pulse that starts a new capture.
- sample_en  in  1  timebase strobe; one write per asserted cycle while capturing.
- trigger  in  1  trigger event, sampled only on a sample_en cycle.
- key_left  in  1  debounced single-cycle pulse: scroll window earlier.
- key_right  in  1  debounced single-cycle pulse: scroll window later.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- trig_addr  out  ADDR_W  address written on the trigger sample.
- capture_done  out  1  high in DONE state.
- rd_addr  out  ADDR_W  RAM read address.
- rd_valid  out  1  rd_addr is meaningful (DONE state).
- rd_sof  out  1  pulses with the first address of each window sweep.

Behaviour:
- Reset: state IDLE. wr_en, wr_addr, trig_addr, capture_done, rd_addr, rd_valid, rd_sof and the scroll offset are all 0. Reset mid-capture aborts the capture immediately.
- Mode latch: depth is computed from frame_mode and latched on arm. frame_mode is ignored at all other times.
- States:
  - IDLE: no writes. arm -> PRETRIG.
  - PRETRIG: counts PRE_TRIG writes; trigger is ignored. After the PRE_TRIG-th write -> ARMED.
  - ARMED: writes wrap through 0..depth-1. A trigger on a sample_en cycle writes that sample, sets trig_addr to its address, and moves to POST.
  - POST: performs depth-PRE_TRIG-1 further writes, then -> DONE.
  - DONE: no writes; read sweep active.
- Writes: registered. wr_en equals sample_en while in PRETRIG/ARMED/POST and the RAM write for that sample uses the current wr_addr in the same cycle. wr_addr then increments, wrapping depth-1 -> 0. On arm, wr_addr is cleared to 0.
- arm in any state restarts the capture: wr_addr 0, capture_done 0, offset 0. arm wins over a simultaneous trigger.
- Scroll offset: range 0..depth-DISP_LEN, saturating at both ends.
  - key_left decrements, key_right increments. Both in one cycle: key_left wins.
  - Keys are accepted in every state.
- Window base = (trig_addr + depth - PRE_TRIG + offset) mod depth. The sum is below 3*depth; reduce with at most two conditional subtractions, never a divider. Base is the oldest retained sample when offset is 0.
- Read sweep in DONE:
  - Entry cycle: rd_addr = base, rd_sof = 1.
  - Each following cycle rd_addr advances by 1 modulo depth.
  - After DISP_LEN addresses it returns to a freshly computed base with rd_sof = 1.
  - Offset and base changes take effect only at sweep restart, so there is no tearing.
- Outside DONE: rd_valid = 0, rd_addr = 0, rd_sof = 0.
- capture_done and rd_valid rise on the first DONE cycle.

Decomposition:
- Shared package scope_pkg holds: the state encoding (IDLE, PRETRIG, ARMED, POST, DONE), FRAME_LEN, MAX_FRAMES, and the depth computation function.
- One sub-module, scope_rd_window, owns the offset register, base computation and read sweep. The top holds the FSM and write counter.

Test Plan:
- Mode 0, sample_en constant 1, arm, trigger asserted 120 writes after arm -> trig_addr = 120; 149 post writes ending at address 69; capture_done rises; sweep runs 70..199, 0..69 with rd_sof at 70.
- Trigger pulses during the first 50 writes after arm -> ignored; state still ARMED after write 50; a later trigger is accepted.
- Mode 1 (depth 400), 5 key_right pulses -> offset 5; 300 key_right pulses -> saturate at 200; key_left and key_right in the same cycle -> offset decrements by 1.
- Key pulse mid-sweep -> current sweep completes unchanged; next rd_sof is at base + 1.
- sample_en every 4th cycle -> wr_addr advances only on strobe cycles; a trigger on a non-strobe cycle is ignored.
- reset asserted in POST, and separately arm asserted in DONE -> after reset all outputs are 0 and state is IDLE; after arm wr_addr = 0, capture_done = 0 and the new capture begins in PRETRIG.
